// File: rtl/count_enable_pkg.sv
// count_enable_pkg: shared types, board defaults and the counter width helper
// for the count_enable_gen slice.
package count_enable_pkg;

   typedef enum logic {
      RUNNING = 1'b0,
      PAUSED  = 1'b1
   } run_state_t;

   localparam int DEF_CLK_HZ       = 50_000_000;
   localparam int DEF_TICK_HZ      = 1;
   localparam int DEF_FAST_MULT    = 10;
   localparam int DEF_DEBOUNCE_CYC = 500_000;

   // bits needed to hold values 0..n-1 (at least one bit)
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser, stable-level counter and one-cycle
// press pulse on each accepted 1->0 transition of an active-low key.
module key_debounce
   import count_enable_pkg::*;
#(
   parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic press
);

   localparam int CW = cnt_w(DEBOUNCE_CYC);
   localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYC - 1);

   logic          s1_q, s2_q;
   logic          lvl_q, lvl_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          press_q, press_d;

   // accept the synchronised level once it has differed for DEBOUNCE_CYC cycles
   always_comb begin
      lvl_d   = lvl_q;
      cnt_d   = '0;
      press_d = 1'b0;
      if (s2_q != lvl_q) begin
         if (cnt_q == CMAX) begin
            lvl_d   = s2_q;
            press_d = ~s2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // synchroniser and debounce state; keys idle released (high)
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q    <= 1'b1;
         s2_q    <= 1'b1;
         lvl_q   <= 1'b1;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         s1_q    <= key_n;
         s2_q    <= s1_q;
         lvl_q   <= lvl_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/count_enable_gen.sv
// count_enable_gen: run/pause FSM and prescaler producing a one-cycle enable.
// COUNT_ENABLE_STEP_KEY_EN compiles in the single-step key and its debouncer.
module count_enable_gen
   import count_enable_pkg::*;
#(
   parameter int CLK_HZ       = DEF_CLK_HZ,
   parameter int TICK_HZ      = DEF_TICK_HZ,
   parameter int FAST_MULT    = DEF_FAST_MULT,
   parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
   input  logic clk,
   input  logic reset,
   input  logic key_run_n,
   input  logic key_step_n,
   input  logic sw_fast,
   output logic enable,
   output logic running
);

   localparam int DIV  = CLK_HZ / TICK_HZ;
   localparam int FDIV = DIV / FAST_MULT;
   localparam int PW   = cnt_w(DIV);
   localparam logic [PW-1:0] DIV_M1  = PW'(DIV - 1);
   localparam logic [PW-1:0] FDIV_M1 = PW'(FDIV - 1);

   logic run_ev;
   logic step_ev;

   key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_run_key (
      .clk   (clk),
      .reset (reset),
      .key_n (key_run_n),
      .press (run_ev)
   );

`ifdef COUNT_ENABLE_STEP_KEY_EN
   key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_step_key (
      .clk   (clk),
      .reset (reset),
      .key_n (key_step_n),
      .press (step_ev)
   );
`else
   logic unused_step;
   assign unused_step = key_step_n;
   assign step_ev     = 1'b0;
`endif

   logic          fs1_q, fs2_q, fprev_q;
   run_state_t    state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          enable_q, enable_d;
   logic [PW-1:0] lim_m1, lim_nx_m1;

   // next state; enable is looked ahead one cycle so it is high exactly while
   // the prescaler sits at LIM-1, and is suppressed in a rate-change cycle
   always_comb begin
      lim_m1    = fs2_q ? FDIV_M1 : DIV_M1;
      lim_nx_m1 = fs1_q ? FDIV_M1 : DIV_M1;
      state_d   = state_q;
      presc_d   = '0;
      enable_d  = 1'b0;
      case (state_q)
         RUNNING: begin
            if (run_ev) begin
               state_d = PAUSED;
            end else begin
               presc_d  = (presc_q >= lim_m1) ? '0 : presc_q + 1'b1;
               enable_d = (presc_d == lim_nx_m1) && (fs1_q == fs2_q);
            end
         end
         PAUSED: begin
            if (run_ev) state_d = RUNNING;
            else        enable_d = step_ev;
         end
         default: state_d = RUNNING;
      endcase
   end

   // switch synchroniser, FSM, prescaler and output register
   always_ff @(posedge clk) begin
      if (reset) begin
         fs1_q    <= 1'b0;
         fs2_q    <= 1'b0;
         fprev_q  <= 1'b0;
         state_q  <= RUNNING;
         presc_q  <= '0;
         enable_q <= 1'b0;
      end else begin
         fs1_q    <= sw_fast;
         fs2_q    <= fs1_q;
         fprev_q  <= fs2_q;
         state_q  <= state_d;
         presc_q  <= presc_d;
         enable_q <= enable_d;
      end
   end

   logic unused_fprev;
   assign unused_fprev = fprev_q;

   assign enable  = enable_q;
   assign running = (state_q == RUNNING);

endmodule

// File: tb/tb_count_enable_gen.sv
// tb_count_enable_gen: directed scenarios plus randomized keys/switch/reset,
// compared each cycle against a cycle-level behavioural model.
module tb_count_enable_gen;

   localparam int CLK_HZ = 1000;
   localparam int TICK_HZ = 100;
   localparam int FAST_MULT = 5;
   localparam int DEB = 4;
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int FDIV = DIV / FAST_MULT;
`ifdef COUNT_ENABLE_STEP_KEY_EN
   localparam bit STEP_EN = 1'b1;
`else
   localparam bit STEP_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic key_run_n = 1'b1;
   logic key_step_n = 1'b1;
   logic sw_fast = 1'b0;
   logic enable;
   logic running;

   count_enable_gen #(
      .CLK_HZ       (CLK_HZ),
      .TICK_HZ      (TICK_HZ),
      .FAST_MULT    (FAST_MULT),
      .DEBOUNCE_CYC (DEB)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .key_run_n  (key_run_n),
      .key_step_n (key_step_n),
      .sw_fast    (sw_fast),
      .enable     (enable),
      .running    (running)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
   endtask

   // behavioural model state, as seen during the current cycle
   bit m_run, m_sp;
   int m_presc;
   bit m_s1, m_f, m_fp;
   bit r1, r2, q1, q2;
   bit lr, ls;
   bit pr_run, pr_step;
   bit wr[$];
   bit ws[$];

   function automatic bit win_all(input bit q[$], input bit v);
      if (q.size() < DEB) return 1'b0;
      for (int i = q.size() - DEB; i < q.size(); i++)
         if (q[i] != v) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit exp_en();
      int lim;
      lim = m_f ? FDIV : DIV;
      return m_sp || (m_run && (m_f == m_fp) && (m_presc == lim - 1));
   endfunction

   task automatic model_edge(input bit rst, input bit kr, input bit ks, input bit sw);
      int lim;
      if (rst) begin
         m_run = 1; m_sp = 0; m_presc = 0;
         m_s1 = 0; m_f = 0; m_fp = 0;
         r1 = 1; r2 = 1; q1 = 1; q2 = 1;
         lr = 1; ls = 1; pr_run = 0; pr_step = 0;
         wr.delete(); ws.delete();
         return;
      end
      lim = m_f ? FDIV : DIV;
      if (pr_run) begin
         m_run = !m_run; m_presc = 0; m_sp = 0;
      end else if (!m_run) begin
         m_presc = 0; m_sp = STEP_EN && pr_step;
      end else begin
         m_sp = 0;
         m_presc = (m_presc >= lim - 1) ? 0 : m_presc + 1;
      end
      m_fp = m_f; m_f = m_s1; m_s1 = sw;
      wr.push_back(r2); r2 = r1; r1 = kr;
      ws.push_back(q2); q2 = q1; q1 = ks;
      while (wr.size() > DEB) void'(wr.pop_front());
      while (ws.size() > DEB) void'(ws.pop_front());
      pr_run = 0;
      if (win_all(wr, !lr)) begin lr = !lr; pr_run = !lr; end
      pr_step = 0;
      if (win_all(ws, !ls)) begin ls = !ls; pr_step = !ls; end
   endtask

   // one clock: drive, let the edge happen, then compare away from it
   task automatic cyc(input bit rst, input bit kr, input bit ks, input bit sw,
                      input string tag);
      reset = rst; key_run_n = kr; key_step_n = ks; sw_fast = sw;
      @(posedge clk);
      model_edge(rst, kr, ks, sw);
      @(negedge clk);
      chk({tag, ".en"}, int'(enable), int'(exp_en()));
      chk({tag, ".run"}, int'(running), int'(m_run));
   endtask

   task automatic press(input bit kr, input bit ks, input bit sw,
                        input string tag, output int npulse);
      npulse = 0;
      repeat (10) begin cyc(0, kr, ks, sw, tag); npulse += int'(enable); end
      repeat (10) begin cyc(0, 1, 1, sw, tag); npulse += int'(enable); end
   endtask

   initial begin
      int fall, cnt, tot, mcnt, first, w;
      bit sw, kr, ks;
      int hr, hs;

      repeat (3) cyc(1, 1, 1, 0, "rst");
      chk("rst.en_val", int'(enable), 0);
      chk("rst.run_val", int'(running), 1);

      for (int c = 0; c < 34; c++) begin
         cyc(0, 1, 1, 0, "idle");
         chk("idle.sched", int'(enable), int'(((c + 1) % DIV) == DIV - 1));
      end

      fall = -1;
      repeat (2) cyc(0, 0, 1, 0, "bounce");
      cyc(0, 1, 1, 0, "bounce");
      for (int i = 0; i < 10; i++) begin
         cyc(0, 0, 1, 0, "bounce");
         if (!running && fall < 0) fall = i + 1;
      end
      chk("bounce.fall_edges", fall, 2 + DEB + 1);
      cnt = 0;
      repeat (20) begin cyc(0, 1, 1, 0, "bounce"); cnt += int'(enable); end
      chk("bounce.no_pulse", cnt, 0);

      tot = 0;
      for (int p = 0; p < 3; p++) begin
         press(1, 0, 0, "stepP", cnt);
         tot += cnt;
      end
      chk("stepP.count", tot, STEP_EN ? 3 : 0);
      chk("stepP.paused", int'(running), 0);

      press(0, 1, 0, "resume", cnt);
      chk("resume.run", int'(running), 1);

      tot = 0; mcnt = 0;
      for (int p = 0; p < 3; p++) begin
         press(1, 0, 0, "stepR", cnt);
         tot += cnt;
      end
      chk("stepR.count", tot, 6);

      w = 0;
      while (!(m_run && m_presc == 7) && w < 30) begin
         cyc(0, 1, 1, 0, "fwait"); w++;
      end
      chk("fast.wait", int'(m_run && m_presc == 7), 1);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(0, 1, 1, 1, "fast");
         if (i < 3) cnt += int'(enable);
         if (i == 9) tot = 0;
         if (i >= 10) tot += int'(enable);
      end
      chk("fast.no_pulse_on_clear", cnt, 0);
      chk("fast.rate", tot, 10 / FDIV);
      tot = 0;
      for (int i = 0; i < 30; i++) begin
         cyc(0, 1, 1, 0, "slow");
         if (i >= 10) tot += int'(enable);
      end
      chk("slow.rate", tot, 20 / DIV);

      press(0, 1, 0, "pause", cnt);
      chk("pause.run", int'(running), 0);
      first = -1;
      for (int i = 0; i < 20; i++) begin
         cyc(0, i < 10 ? 1'b0 : 1'b1, i < 10 ? 1'b0 : 1'b1, 0, "simul");
         if (enable && first < 0) first = i;
      end
      chk("simul.first", first, DEB + 1 + DIV);
      chk("simul.run", int'(running), 1);

      repeat (3) cyc(0, 0, 1, 0, "rstmid");
      cyc(1, 1, 1, 0, "rstmid");
      chk("rstmid.en", int'(enable), 0);
      chk("rstmid.run", int'(running), 1);
      for (int i = 0; i < 15; i++) cyc(0, 1, 1, 0, "rstmid");

      sw = 0; kr = 1; ks = 1; hr = 0; hs = 0;
      for (int i = 0; i < 4000; i++) begin
         if (hr == 0) begin kr = 1'($urandom % 2); hr = $urandom_range(1, 12); end
         if (hs == 0) begin ks = 1'($urandom % 2); hs = $urandom_range(1, 12); end
         hr--; hs--;
         if ($urandom_range(0, 59) == 0) sw = !sw;
         cyc($urandom_range(0, 799) == 0, kr, ks, sw, "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
